// File: rtl/coax_bus_ctrl.sv
// coax_bus_ctrl: owns the shared 10-bit bus between the DP8341 receiver read
// path and the DP8340 transmitter load path. Received words land in a
// first-word-fall-through FIFO offered to the host as a valid/ready stream.
// Host transmit words are registered and loaded into the transmitter.
// Only one agent drives the bus at a time, and a turnaround gap separates owners.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready.
// On rx_*, rx_ready may be held high at any time; a pop happens only when
// rx_valid is also high. On tx_*, tx_ready is a one-cycle registered pulse
// saying that the tx_data presented on the previous edge was taken.
// The host must hold tx_data/tx_valid steady until it sees that pulse.
//
// Optional build macro: COAX_BUS_CTRL_STATS_EN adds saturating 16-bit
// rx/tx word counters. When it is undefined, both count outputs are tied to 0.
module coax_bus_ctrl #(
   parameter int FIFO_DEPTH        = 16,
   parameter int SETTLE_CYCLES     = 2,
   parameter int STROBE_CYCLES     = 2,
   parameter int TURNAROUND_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_data_available,
   output logic        rx_output_enable,
   output logic        rx_register_read_n,
   input  logic        tx_full,
   output logic        tx_register_load_n,
   input  logic [9:0]  bus_in,
   output logic [9:0]  bus_out,
   output logic        bus_oe,
   output logic [9:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic [9:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [15:0] rx_word_count,
   output logic [15:0] tx_word_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = 8;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] TURN_LAST   = CW'(TURNAROUND_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RX_EN, RX_STROBE, TX_DRIVE, TX_STROBE, TURN} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_next_cnt;
   logic            r_last_rx;
   logic            w_grant_rx;
   logic            w_grant_tx;
   logic            w_rx_req;
   logic            w_tx_req;
   logic            w_fifo_full;

   logic            r_rx_oe;
   logic            r_rd_n;
   logic            r_bus_oe;
   logic            r_ld_n;
   logic            r_tx_ready;
   logic [9:0]      r_bus_out;

   logic [9:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            r_rx_valid;
   logic [9:0]      r_rx_data;
   logic            w_push;
   logic            w_pop;
   logic [AW-1:0]   w_rd_next;
   logic [AW:0]     w_count_next;
   logic [9:0]      w_head_next;

   assign w_fifo_full = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_rx_req    = rx_data_available && !w_fifo_full;
   assign w_tx_req    = tx_valid && !tx_full;

   // Next-state logic: round-robin arbitration in IDLE, cycle counting elsewhere
   always_comb begin
      w_next_state = r_state;
      w_grant_rx   = 1'b0;
      w_grant_tx   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rx_req && (!w_tx_req || !r_last_rx)) begin
               w_grant_rx   = 1'b1;
               w_next_state = RX_EN;
            end else if (w_tx_req) begin
               w_grant_tx   = 1'b1;
               w_next_state = TX_DRIVE;
            end
         end
         RX_EN:     if (r_cnt == SETTLE_LAST) w_next_state = RX_STROBE;
         RX_STROBE: if (r_cnt == STROBE_LAST) w_next_state = TURN;
         TX_DRIVE:  if (r_cnt == SETTLE_LAST) w_next_state = TX_STROBE;
         TX_STROBE: if (r_cnt == STROBE_LAST) w_next_state = TURN;
         TURN:      if (r_cnt == TURN_LAST)   w_next_state = IDLE;
         default:   w_next_state = IDLE;
      endcase
      w_next_cnt = r_cnt + CW'(1);
      if (w_next_state != r_state || w_next_state == IDLE) begin
         w_next_cnt = '0;
      end
   end

   // State register, phase counter and round-robin pointer (0 = RX favoured)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_last_rx <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_grant_rx) r_last_rx <= 1'b1;
         if (w_grant_tx) r_last_rx <= 1'b0;
      end
   end

   // Bus-facing outputs registered from the next state so they change cleanly with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_oe    <= 1'b0;
         r_rd_n     <= 1'b1;
         r_bus_oe   <= 1'b0;
         r_ld_n     <= 1'b1;
         r_tx_ready <= 1'b0;
         r_bus_out  <= '0;
      end else begin
         r_rx_oe    <= (w_next_state == RX_EN) || (w_next_state == RX_STROBE);
         r_rd_n     <= (w_next_state != RX_STROBE);
         r_bus_oe   <= (w_next_state == TX_DRIVE) || (w_next_state == TX_STROBE);
         r_ld_n     <= (w_next_state != TX_STROBE);
         r_tx_ready <= w_grant_tx;
         if (w_grant_tx) r_bus_out <= tx_data;
      end
   end

   // FIFO next-state: the head is precomputed so rx_data leaves a register
   always_comb begin
      w_push       = (r_state == RX_EN) && (r_cnt == SETTLE_LAST);
      w_pop        = r_rx_valid && rx_ready;
      w_rd_next    = r_rd_ptr + AW'(w_pop);
      w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      w_head_next  = r_mem[w_rd_next];
      if (w_push && (w_rd_next == r_wr_ptr)) w_head_next = bus_in;
      if (w_count_next == '0)                w_head_next = '0;
   end

   // FIFO pointers, fill count and registered head
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr   <= w_rd_next;
         r_count    <= w_count_next;
         r_rx_valid <= (w_count_next != '0);
         r_rx_data  <= w_head_next;
      end
   end

   // FIFO storage: contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus_in;
   end

`ifdef COAX_BUS_CTRL_STATS_EN
   logic [15:0] r_rx_words;
   logic [15:0] r_tx_words;

   // Saturating word counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_words <= '0;
         r_tx_words <= '0;
      end else begin
         if (w_push && r_rx_words != 16'hFFFF)     r_rx_words <= r_rx_words + 16'd1;
         if (r_tx_ready && r_tx_words != 16'hFFFF) r_tx_words <= r_tx_words + 16'd1;
      end
   end

   assign rx_word_count = r_rx_words;
   assign tx_word_count = r_tx_words;
`else
   assign rx_word_count = '0;
   assign tx_word_count = '0;
`endif

   assign rx_output_enable   = r_rx_oe;
   assign rx_register_read_n = r_rd_n;
   assign bus_oe             = r_bus_oe;
   assign tx_register_load_n = r_ld_n;
   assign tx_ready           = r_tx_ready;
   assign bus_out            = r_bus_out;
   assign rx_valid           = r_rx_valid;
   assign rx_data            = r_rx_data;

endmodule

// File: tb/tb_coax_bus_ctrl.sv
// Directed bench for coax_bus_ctrl. The DUT is built with FIFO_DEPTH=4 so the
// full-FIFO case is reachable; the other parameters keep their default values.
// A receiver model and a host model run once per cycle inside step().
module tb_coax_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        rx_data_available;
   logic        tx_full;
   logic        rx_ready;
   logic        tx_valid;
   logic [9:0]  bus_in;
   logic [9:0]  tx_data;
   logic        rx_output_enable;
   logic        rx_register_read_n;
   logic        tx_register_load_n;
   logic        bus_oe;
   logic        rx_valid;
   logic        tx_ready;
   logic [9:0]  bus_out;
   logic [9:0]  rx_data;
   logic [15:0] rx_word_count;
   logic [15:0] tx_word_count;

   coax_bus_ctrl #(
      .FIFO_DEPTH       (4),
      .SETTLE_CYCLES    (2),
      .STROBE_CYCLES    (2),
      .TURNAROUND_CYCLES(1)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .rx_data_available (rx_data_available),
      .rx_output_enable  (rx_output_enable),
      .rx_register_read_n(rx_register_read_n),
      .tx_full           (tx_full),
      .tx_register_load_n(tx_register_load_n),
      .bus_in            (bus_in),
      .bus_out           (bus_out),
      .bus_oe            (bus_oe),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .rx_word_count     (rx_word_count),
      .tx_word_count     (tx_word_count)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Scoreboard state
   logic [9:0] rx_src_q [$];
   logic [9:0] tx_src_q [$];
   logic [9:0] exp_q [$];
   logic [9:0] tx_exp_q [$];
   int         grants [$];
   int         n_checks;
   int         n_pass;
   int         pop_budget;
   int         rd_count;
   int         ld_count;
   logic       prev_rd_n;
   logic       prev_ld_n;
   logic       prev_rx_oe;
   logic       prev_bus_oe;
   logic [7:0] tr_rx_oe;
   logic [7:0] tr_rd_n;
   logic [7:0] tr_rx_valid;
   logic [7:0] tr_bus_oe;
   logic [7:0] tr_ld_n;
   logic [7:0] tr_tx_ready;
   logic [9:0] tr_bus_out0;
   logic [15:0] exp_rx_words;
   logic [15:0] exp_tx_words;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock cycle: sample on the falling edge, run the models, drive inputs
   task automatic step();
      @(negedge clk);
      check("no_overlap", 32'(rx_output_enable & bus_oe), 0);
      if (!rx_register_read_n && prev_rd_n) begin
         rd_count++;
         if (rx_src_q.size() != 0) exp_q.push_back(rx_src_q.pop_front());
      end
      if (rx_output_enable && !prev_rx_oe) grants.push_back(0);
      if (bus_oe && !prev_bus_oe)          grants.push_back(1);
      if (tx_ready && tx_src_q.size() != 0) tx_exp_q.push_back(tx_src_q.pop_front());
      if (!tx_register_load_n && prev_ld_n) begin
         ld_count++;
         check("tx_load_oe", 32'(bus_oe), 1);
         check("tx_pending", 32'(tx_exp_q.size() != 0), 1);
         if (tx_exp_q.size() != 0) check("tx_load_word", 32'(bus_out), 32'(tx_exp_q.pop_front()));
      end
      rx_ready = 1'b0;
      if (rx_valid && pop_budget > 0) begin
         check("rx_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         rx_ready = 1'b1;
         pop_budget--;
      end
      prev_rd_n   = rx_register_read_n;
      prev_ld_n   = tx_register_load_n;
      prev_rx_oe  = rx_output_enable;
      prev_bus_oe = bus_oe;
      rx_data_available = (rx_src_q.size() != 0);
      bus_in            = (rx_src_q.size() != 0) ? rx_src_q[0] : 10'h000;
      tx_valid          = (tx_src_q.size() != 0);
      tx_data           = (tx_src_q.size() != 0) ? tx_src_q[0] : 10'h000;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic reset_assert();
      reset = 1'b1;
      rx_src_q.delete();
      tx_src_q.delete();
      exp_q.delete();
      tx_exp_q.delete();
      grants.delete();
      pop_budget = 0;
      rd_count   = 0;
      ld_count   = 0;
      rx_ready   = 1'b0;
      rx_data_available = 1'b0;
      tx_valid   = 1'b0;
      bus_in     = 10'h000;
      tx_data    = 10'h000;
      prev_rd_n  = 1'b1;
      prev_ld_n  = 1'b1;
      prev_rx_oe = 1'b0;
      prev_bus_oe = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_release();
      @(negedge clk);
      reset = 1'b0;
      rx_data_available = (rx_src_q.size() != 0);
      bus_in            = (rx_src_q.size() != 0) ? rx_src_q[0] : 10'h000;
      tx_valid          = (tx_src_q.size() != 0);
      tx_data           = (tx_src_q.size() != 0) ? tx_src_q[0] : 10'h000;
   endtask

   // Bit i of each trace holds the output seen i cycles after the first step
   task automatic trace8();
      for (int i = 0; i < 8; i++) begin
         step();
         tr_rx_oe[i]    = rx_output_enable;
         tr_rd_n[i]     = rx_register_read_n;
         tr_rx_valid[i] = rx_valid;
         tr_bus_oe[i]   = bus_oe;
         tr_ld_n[i]     = tx_register_load_n;
         tr_tx_ready[i] = tx_ready;
         if (i == 0) tr_bus_out0 = bus_out;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      tx_full  = 1'b0;

      // Reset values
      reset_assert();
      check("rst_rx_oe",  32'(rx_output_enable), 0);
      check("rst_bus_oe", 32'(bus_oe), 0);
      check("rst_bus_out", 32'(bus_out), 0);
      check("rst_tx_ready", 32'(tx_ready), 0);
      check("rst_rd_n",   32'(rx_register_read_n), 1);
      check("rst_ld_n",   32'(tx_register_load_n), 1);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      reset_release();

      // RX only, single word
      rx_src_q.push_back(10'h2A5);
      step();
      trace8();
      check("rx_oe_trace",    32'(tr_rx_oe),    32'h0F);
      check("rx_rd_n_trace",  32'(tr_rd_n),     32'hF3);
      check("rx_valid_trace", 32'(tr_rx_valid), 32'hFC);
      check("rx_bus_oe_trace", 32'(tr_bus_oe),  32'h00);
      check("rx_head", 32'(rx_data), 32'h2A5);
      pop_budget = 1;
      run(2);
      check("rx_empty_after_pop", 32'(rx_valid), 0);
      check("rx_sb_drained", 32'(exp_q.size()), 0);

      // TX only, two words back to back
      reset_assert();
      reset_release();
      tx_src_q.push_back(10'h155);
      tx_src_q.push_back(10'h0AA);
      step();
      trace8();
      check("tx_ready_trace", 32'(tr_tx_ready), 32'h41);
      check("tx_bus_oe_trace", 32'(tr_bus_oe),  32'hCF);
      check("tx_ld_n_trace",  32'(tr_ld_n),     32'hF3);
      check("tx_rx_oe_trace", 32'(tr_rx_oe),    32'h00);
      check("tx_bus_out0",    32'(tr_bus_out0), 32'h155);
      run(8);
      check("tx_load_count", 32'(ld_count), 2);
      check("tx_sb_drained", 32'(tx_exp_q.size() + tx_src_q.size()), 0);

      // tx_full holds off TX grants
      reset_assert();
      reset_release();
      tx_full = 1'b1;
      tx_src_q.push_back(10'h3C3);
      run(10);
      check("tx_full_blocks", 32'(grants.size()), 0);
      tx_full = 1'b0;
      run(10);
      check("tx_after_full", 32'(ld_count), 1);

      // Both sides requesting from reset: grants alternate starting with RX
      reset_assert();
      for (int i = 0; i < 3; i++) begin
         rx_src_q.push_back(10'(10'h100 + i));
         tx_src_q.push_back(10'(10'h200 + i));
      end
      pop_budget = 1000;
      reset_release();
      for (int i = 0; i < 60 && grants.size() < 4; i++) step();
      for (int i = 0; i < 4; i++) begin
         check("grant_order", 32'((grants.size() > i) ? grants[i] : -1), 32'(i % 2));
      end
      run(30);
      check("alt_rx_drained", 32'(exp_q.size() + rx_src_q.size()), 0);
      check("alt_tx_loads", 32'(ld_count), 3);

      // FIFO_DEPTH=4 fills; fifth read waits for a pop
      reset_assert();
      for (int i = 0; i < 6; i++) rx_src_q.push_back(10'(10'h040 + 3 * i));
      reset_release();
      run(40);
      check("fifo_full_reads", 32'(rd_count), 4);
      check("fifo_full_pending", 32'(rx_src_q.size()), 2);
      check("fifo_full_valid", 32'(rx_valid), 1);
      pop_budget = 1;
      run(12);
      check("fifo_fifth_read", 32'(rd_count), 5);
      pop_budget = 1000;
      run(30);
      check("fifo_all_read", 32'(rd_count), 6);
      check("fifo_sb_drained", 32'(exp_q.size()), 0);
      check("fifo_empty", 32'(rx_valid), 0);

      // Reset during RX_STROBE aborts the transaction asynchronously
      reset_assert();
      rx_src_q.push_back(10'h0F0);
      reset_release();
      for (int i = 0; i < 20 && rx_register_read_n; i++) step();
      check("strobe_reached", 32'(rx_register_read_n), 0);
      #1 reset = 1'b1;
      #1;
      check("abort_rx_oe",  32'(rx_output_enable), 0);
      check("abort_rd_n",   32'(rx_register_read_n), 1);
      check("abort_bus_oe", 32'(bus_oe), 0);
      check("abort_ld_n",   32'(tx_register_load_n), 1);
      check("abort_rx_valid", 32'(rx_valid), 0);
      reset_assert();
      rx_src_q.push_back(10'h011);
      tx_src_q.push_back(10'h022);
      pop_budget = 1000;
      reset_release();
      check("post_abort_rx_valid", 32'(rx_valid), 0);
      for (int i = 0; i < 20 && grants.size() == 0; i++) step();
      check("post_abort_rx_first", 32'((grants.size() > 0) ? grants[0] : 9), 0);
      run(20);

      // Word counters after 3 RX and 2 TX transactions
      reset_assert();
      for (int i = 0; i < 3; i++) rx_src_q.push_back(10'(10'h300 + i));
      for (int i = 0; i < 2; i++) tx_src_q.push_back(10'(10'h0C0 + i));
      pop_budget = 1000;
      reset_release();
      run(50);
`ifdef COAX_BUS_CTRL_STATS_EN
      exp_rx_words = 16'd3;
      exp_tx_words = 16'd2;
`else
      exp_rx_words = 16'd0;
      exp_tx_words = 16'd0;
`endif
      check("rx_word_count", 32'(rx_word_count), 32'(exp_rx_words));
      check("tx_word_count", 32'(tx_word_count), 32'(exp_tx_words));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
